// File: rtl/mvm_ctrl_pkg.sv
// Shared state encoding and default geometry for the matrix-vector FIFO sequencer.
// Pure declarations: no logic, no latency, no flow control.
package mvm_ctrl_pkg;

  localparam int DEF_NUM_FIFOS  = 9;
  localparam int DEF_DEPTH      = 8;
  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    FILL,
    DRAIN,
    TAIL,
    DONE
  } state_t;

endpackage

// File: rtl/mvm_fifo_ctrl_word_serializer.sv
// Loads one memory word and presents it a byte at a time, LSB byte first.
// Byte output is valid the cycle after load; advances only on an accepted write.
module word_serializer
  import mvm_ctrl_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_load,
  input  logic [DEPTH*DATA_WIDTH-1:0]   i_word,
  input  logic                          i_adv,
  output logic [DATA_WIDTH-1:0]         o_byte
);

  logic [DEPTH*DATA_WIDTH-1:0] r_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
    end else if (i_load) begin
      r_shift <= i_word;
    end else if (i_adv) begin
      r_shift <= r_shift >> DATA_WIDTH;
    end
  end

  assign o_byte = r_shift[DATA_WIDTH-1:0];

endmodule

// File: rtl/mvm_fifo_ctrl.sv
// Fetches one word per FIFO, serializes it into the bank, then drains all FIFOs in lockstep to the MACs.
// One-cycle memory handshake per word; stalls on fifo_full while filling and on any fifo_empty while draining.
module mvm_fifo_ctrl
  import mvm_ctrl_pkg::*;
#(
  parameter int                  NUM_FIFOS  = DEF_NUM_FIFOS,
  parameter int                  DEPTH      = DEF_DEPTH,
  parameter int                  DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int                  ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          mem_rd,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  input  logic                          mem_valid,
  input  logic [DEPTH*DATA_WIDTH-1:0]   mem_data,
  output logic [NUM_FIFOS-1:0]          fifo_wren,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  input  logic [NUM_FIFOS-1:0]          fifo_full,
  output logic [NUM_FIFOS-1:0]          fifo_rden,
  input  logic [NUM_FIFOS-1:0]          fifo_empty,
  output logic                          mac_en,
  output logic                          mac_clr
);

  localparam int IW = $clog2(NUM_FIFOS);
  localparam int CW = $clog2(DEPTH) + 1;

  state_t                r_state;
  state_t                w_next;
  logic [IW-1:0]         r_fifo_idx;
  logic [CW-1:0]         r_byte_cnt;
  logic [CW-1:0]         r_rd_cnt;
  logic                  r_mac_en;
  logic                  w_load;
  logic                  w_wr_ok;
  logic                  w_rd_ok;
  logic                  w_last_fifo;
  logic                  w_last_byte;
  logic                  w_last_rd;
  logic [DATA_WIDTH-1:0] w_byte;

  assign w_wr_ok     = (r_state == FILL) && !fifo_full[r_fifo_idx];
  assign w_rd_ok     = (r_state == DRAIN) && !(|fifo_empty);
  assign w_last_fifo = (r_fifo_idx == IW'(NUM_FIFOS - 1));
  assign w_last_byte = (r_byte_cnt == CW'(DEPTH - 1));
  assign w_last_rd   = (r_rd_cnt == CW'(DEPTH - 1));

  word_serializer #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ser (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_word (mem_data),
    .i_adv  (w_wr_ok),
    .o_byte (w_byte)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // All strobes decode from the registered state, so an async reset clears them at once.
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    busy       = (r_state != IDLE);
    done       = 1'b0;
    mem_rd     = 1'b0;
    mem_addr   = '0;
    fifo_wren  = '0;
    fifo_wdata = '0;
    fifo_rden  = '0;
    mac_clr    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          mac_clr = 1'b1;
          w_next  = REQ;
        end
      end
      REQ: begin
        mem_rd   = 1'b1;
        mem_addr = ADDR_BASE + ADDR_WIDTH'(r_fifo_idx);
        w_next   = WAIT;
      end
      WAIT: begin
        if (mem_valid) begin
          w_load = 1'b1;
          w_next = FILL;
        end
      end
      FILL: begin
        if (w_wr_ok) begin
          fifo_wren[r_fifo_idx] = 1'b1;
          fifo_wdata            = w_byte;
          if (w_last_byte) begin
            w_next = w_last_fifo ? DRAIN : REQ;
          end
        end
      end
      DRAIN: begin
        if (w_rd_ok) begin
          fifo_rden = '1;
          if (w_last_rd) begin
            w_next = TAIL;
          end
        end
      end
      TAIL: w_next = DONE;
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fifo_idx <= '0;
      r_byte_cnt <= '0;
      r_rd_cnt   <= '0;
      r_mac_en   <= 1'b0;
    end else begin
      // FIFO read data lands one cycle after rden, so the MAC enable trails it.
      r_mac_en <= w_rd_ok;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_fifo_idx <= '0;
            r_rd_cnt   <= '0;
          end
        end
        WAIT: begin
          if (mem_valid) begin
            r_byte_cnt <= '0;
          end
        end
        FILL: begin
          if (w_wr_ok) begin
            r_byte_cnt <= r_byte_cnt + CW'(1);
            if (w_last_byte && !w_last_fifo) begin
              r_fifo_idx <= r_fifo_idx + IW'(1);
            end
          end
        end
        DRAIN: begin
          if (w_rd_ok) begin
            r_rd_cnt <= r_rd_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign mac_en = r_mac_en;

endmodule

// File: tb/tb_mvm_fifo_ctrl.sv
// Randomized bench for mvm_fifo_ctrl against queue-based FIFO and memory models.
// Expected timing is derived from per-word cycle arithmetic, not from the controller's states.
module tb_mvm_fifo_ctrl;

  localparam int NF = 9;
  localparam int DP = 8;
  localparam int DW = 8;
  localparam int AW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              busy;
  logic              done;
  logic              mem_rd;
  logic [AW-1:0]     mem_addr;
  logic              mem_valid;
  logic [DP*DW-1:0]  mem_data;
  logic [NF-1:0]     fifo_wren;
  logic [DW-1:0]     fifo_wdata;
  logic [NF-1:0]     fifo_full;
  logic [NF-1:0]     fifo_rden;
  logic [NF-1:0]     fifo_empty;
  logic              mac_en;
  logic              mac_clr;

  mvm_fifo_ctrl #(
    .NUM_FIFOS  (NF),
    .DEPTH      (DP),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .ADDR_BASE  ('0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_valid  (mem_valid),
    .mem_data   (mem_data),
    .fifo_wren  (fifo_wren),
    .fifo_wdata (fifo_wdata),
    .fifo_full  (fifo_full),
    .fifo_rden  (fifo_rden),
    .fifo_empty (fifo_empty),
    .mac_en     (mac_en),
    .mac_clr    (mac_clr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int cyc = 0;
  int t0  = 0;
  int lat, resp_cyc, resp_idx;
  int ff_idx, ff_from, ff_len, em_from, em_len, busy_start, rst_at;
  int exp_done;
  bit chk_busy;
  logic [DP*DW-1:0] words [NF];
  logic [DW-1:0]    q    [NF][$];
  logic [DW-1:0]    wlog [NF][$];
  int addr_log [$];
  int n_done, done_rel, n_mac, first_mac, last_mac, n_rden;
  logic prev_rden;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (rel cycle %0d)", tag, got, exp, cyc - t0);
    end
  endtask

  task automatic tick();
    int  rel;
    bit  viol;
    @(posedge clk);
    cyc++;
    #1;
    rel       = cyc - t0;
    start     = (rel == 0) || (rel == busy_start);
    rst       = (rel == rst_at);
    mem_valid = (cyc == resp_cyc);
    mem_data  = mem_valid ? words[resp_idx] : {$urandom, $urandom};
    if (rst) begin
      for (int i = 0; i < NF; i++) q[i].delete();
    end
    for (int i = 0; i < NF; i++) begin
      fifo_full[i]  = (q[i].size() >= DP) ||
                      (i == ff_idx && rel >= ff_from && rel < ff_from + ff_len);
      fifo_empty[i] = (q[i].size() == 0) ||
                      (i == NF - 1 && rel >= em_from && rel < em_from + em_len);
    end
    @(negedge clk);
    if (rst) begin
      check_eq("rst_outputs", {busy, done, mem_rd, mem_addr, fifo_wren, fifo_wdata,
                               fifo_rden, mac_en, mac_clr}, '0);
      resp_cyc  = -1;
      prev_rden = 1'b0;
      return;
    end
    if ((|fifo_wren) || (|fifo_rden)) begin
      viol = ($countones(fifo_wren) > 1) || (|(fifo_wren & fifo_full)) ||
             ((|fifo_rden) && (fifo_rden != '1)) || ((|fifo_rden) && (|fifo_empty)) ||
             ((|fifo_wren) && (|fifo_rden));
      check_eq("strobe_rules", viol, 1'b0);
    end
    check_eq("mac_en_follows_rden", mac_en, prev_rden);
    check_eq("mac_clr", mac_clr, rel == 0);
    if (chk_busy) check_eq("busy", busy, (rel >= 1) && (rel <= exp_done));
    for (int i = 0; i < NF; i++) begin
      if (fifo_wren[i]) begin
        q[i].push_back(fifo_wdata);
        wlog[i].push_back(fifo_wdata);
      end
    end
    if (|fifo_rden) begin
      n_rden++;
      for (int i = 0; i < NF; i++) if (q[i].size() > 0) void'(q[i].pop_front());
    end
    prev_rden = |fifo_rden;
    if (mac_en) begin
      n_mac++;
      if (first_mac < 0) first_mac = rel;
      last_mac = rel;
    end
    if (mem_rd) begin
      addr_log.push_back(int'(mem_addr));
      resp_cyc = cyc + lat;
      resp_idx = (mem_addr < NF) ? int'(mem_addr) : 0;
    end
    if (done) begin
      n_done++;
      done_rel = rel;
    end
  endtask

  task automatic run_pass(input int l, input bit pat, input int fidx, input int flen,
                          input int elen, input int bstart, input int rat);
    int drain_start;
    logic [DP*DW-1:0] got;
    lat         = l;
    ff_idx      = fidx;
    ff_len      = flen;
    em_len      = elen;
    busy_start  = bstart;
    rst_at      = rat;
    // Each word costs one REQ cycle, l wait cycles and DEPTH fill cycles.
    ff_from     = 2 + l + fidx * (9 + l) + 2;
    drain_start = 1 + NF * (9 + l) + flen;
    em_from     = drain_start + 3;
    exp_done    = 100 + NF * (l - 1) + flen + elen;
    for (int i = 0; i < NF; i++) begin
      if (pat) begin
        for (int b = 0; b < DP; b++) words[i][b*DW +: DW] = DW'(i + 1);
      end else begin
        words[i] = {$urandom, $urandom};
      end
      wlog[i].delete();
    end
    addr_log.delete();
    n_done = 0; done_rel = -1; n_mac = 0; first_mac = -1; last_mac = -1; n_rden = 0;
    chk_busy = (rat < 0);
    t0 = cyc + 1;
    for (int k = 0; k < 800; k++) begin
      tick();
      if (rat >= 0) begin
        if (cyc - t0 >= rat + 3) break;
      end else if (n_done > 0 && cyc - t0 >= done_rel + 4) begin
        break;
      end
    end
    if (rat >= 0) begin
      check_eq("busy_after_rst", busy, 1'b0);
      check_eq("no_done_after_rst", n_done, 0);
    end else begin
      check_eq("done_count", n_done, 1);
      check_eq("done_cycle", done_rel, exp_done);
      check_eq("mac_en_count", n_mac, DP);
      check_eq("rden_count", n_rden, DP);
      check_eq("first_mac_en", first_mac, drain_start + 1);
      check_eq("last_mac_en", last_mac, exp_done - 1);
      check_eq("mem_rd_count", addr_log.size(), NF);
      for (int i = 0; i < NF && i < addr_log.size(); i++)
        check_eq($sformatf("addr_order%0d", i), addr_log[i], i);
      for (int i = 0; i < NF; i++) begin
        got = '0;
        for (int b = 0; b < DP && b < wlog[i].size(); b++) got[b*DW +: DW] = wlog[i][b];
        check_eq($sformatf("fifo%0d_count", i), wlog[i].size(), DP);
        check_eq($sformatf("fifo%0d_bytes", i), got, words[i]);
      end
      for (int i = 0; i < NF; i++)
        check_eq($sformatf("fifo%0d_drained", i), q[i].size(), 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mem_valid = 1'b0; mem_data = '0;
    fifo_full = '0; fifo_empty = '1; resp_cyc = -1; resp_idx = 0; lat = 1;
    ff_idx = -1; ff_from = -1000; ff_len = 0; em_from = -1000; em_len = 0;
    busy_start = -1000; rst_at = -1000; exp_done = 0; chk_busy = 1'b0; prev_rden = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_state", {busy, done, mem_rd, mem_addr, fifo_wren, fifo_wdata,
                             fifo_rden, mac_en, mac_clr}, '0);
    @(posedge clk);
    #1 rst = 1'b0;

    run_pass(1, 1'b1, -1, 0, 0, -1000, -1000);
    run_pass(3, 1'b1, -1, 0, 0, -1000, -1000);
    run_pass(1, 1'b1,  2, 5, 0, -1000, -1000);
    run_pass(1, 1'b1, -1, 0, 2, -1000, -1000);
    run_pass(1, 1'b1, -1, 0, 0, -1000, 40);
    run_pass(1, 1'b1, -1, 0, 0, -1000, -1000);
    run_pass(1, 1'b1, -1, 0, 0, 50, -1000);
    for (int r = 0; r < 6; r++) begin
      run_pass($urandom_range(1, 4), 1'b0, $urandom_range(0, NF - 1),
               $urandom_range(0, 6), $urandom_range(0, 4), -1000, -1000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mvm_fifo_ctrl.md
# mvm_fifo_ctrl

Sequencer for the minilab matrix-vector datapath. It fetches packed words from memory, serializes them byte-by-byte into a bank of FIFOs (one per matrix row plus one for the vector), then drains all FIFOs in lockstep into the MAC array and signals completion. It sits between the memory read port and the FIFO/MAC bank and owns every FIFO `wren`/`rden` strobe.

## Interface
Parameters:
- NUM_FIFOS, 9, FIFOs in the bank. Indices 0..NUM_FIFOS-2 are matrix rows; the last index is the vector.
- DEPTH, 8, entries per FIFO, which is also bytes per memory word.
- DATA_WIDTH, 8, FIFO entry width.
- ADDR_WIDTH, 32, memory address width.
- ADDR_BASE, 0, address of the word for FIFO 0. FIFO i uses ADDR_BASE+i.

Ports:
- clk  in  1  single clock for the block.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle request to run one complete fill/drain pass.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the pass completes.
- mem_rd  out  1  one-cycle read request.
- mem_addr  out  ADDR_WIDTH  read address; valid while mem_rd is high.
- mem_valid  in  1  read data valid.
- mem_data  in  DEPTH*DATA_WIDTH  read word; byte 0 is bits [DATA_WIDTH-1:0].
- fifo_wren  out  NUM_FIFOS  one-hot write strobe.
- fifo_wdata  out  DATA_WIDTH  data shared by all FIFOs.
- fifo_full  in  NUM_FIFOS  per-FIFO full flag.
- fifo_rden  out  NUM_FIFOS  read strobes; either all high or all low.
- fifo_empty  in  NUM_FIFOS  per-FIFO empty flag.
- mac_en  out  1  MAC accumulate enable; FIFO outputs are valid in this cycle.
- mac_clr  out  1  one-cycle MAC accumulator clear.

## Operation
- Reset values: all outputs are 0. State is IDLE and all counters are 0.
- IDLE
  - When start=1, pulse mac_clr, set fifo_idx=0, and go to REQ.
  - start is ignored in every other state.
- REQ
  - Drive mem_rd=1 and mem_addr=ADDR_BASE+fifo_idx for exactly one cycle, then go to WAIT.
- WAIT
  - Hold until mem_valid=1.
  - On that cycle, latch mem_data into the serializer, set byte_cnt=0, and go to FILL.
  - mem_valid is ignored in all other states.
- FILL
  - Each cycle, if fifo_full[fifo_idx]=0: drive fifo_wren[fifo_idx]=1 with fifo_wdata equal to the current byte (LSB byte first), then advance the serializer and byte_cnt.
  - If fifo_full[fifo_idx]=1: stall with wren low and the byte held.
  - After byte DEPTH-1 is written:
    - If fifo_idx=NUM_FIFOS-1, go to DRAIN.
    - Otherwise increment fifo_idx and go to REQ.
- DRAIN
  - Each cycle, if all fifo_empty bits are 0: assert every fifo_rden bit and increment rd_cnt.
  - If any FIFO is empty: hold all rden low (stall).
  - After DEPTH reads, go to TAIL.
- TAIL
  - One cycle, then go to DONE.
- DONE
  - Assert done=1 for one cycle, then go to IDLE.
- mac_en is the one-cycle-delayed copy of "rden issued", since FIFO data appears the cycle after rdreq. There are exactly DEPTH mac_en pulses per pass.
- Invariants:
  - wren is never asserted to a full FIFO.
  - rden is never asserted while any FIFO is empty.
  - wren and rden are never high in the same cycle.
- Counters: fifo_idx is $clog2(NUM_FIFOS) bits; byte_cnt and rd_cnt are $clog2(DEPTH)+1 bits. No wrap occurs within a pass.

## Timing
- The start edge is cycle 0.
- With mem_valid arriving the cycle after mem_rd and no stalls, FIFO i occupies:
  - REQ at cycle 1+10i
  - WAIT at 2+10i
  - FILL at 3+10i through 10+10i
- With defaults:
  - DRAIN rden: cycles 91–98
  - mac_en: cycles 92–99
  - TAIL: cycle 99
  - done: cycle 100
- Each extra memory latency cycle or full/empty stall cycle adds one cycle.
- Asserting rst mid-pass returns the block to IDLE immediately, with all strobes low in the same cycle. FIFO contents are the FIFOs' concern and are cleared by their own reset.

## Structure
- Package mvm_ctrl_pkg holds:
  - the state enum: IDLE, REQ, WAIT, FILL, DRAIN, TAIL, DONE
  - default constants for NUM_FIFOS, DEPTH, DATA_WIDTH
- One sub-module, word_serializer, contains:
  - a load/shift register of DEPTH*DATA_WIDTH bits
  - a byte output
  - an advance input gated by the write-accept

## Test plan
- Basic pass: memory word i = {8{8'(i+1)}} with 1-cycle latency, start at cycle 0.
  - FIFO i receives 8 bytes of value i+1.
  - done at cycle 100.
  - Exactly 8 mac_en pulses at cycles 92–99.
- Memory latency of 3 cycles.
  - done at cycle 118.
  - Addresses issued are 0..8, in order.
- Hold fifo_full[2]=1 for 5 cycles during FILL of FIFO 2.
  - No wren during those cycles.
  - Byte order is preserved.
  - done is delayed by exactly 5 cycles.
- Force fifo_empty[8]=1 for 2 cycles during DRAIN.
  - rden and mac_en are both suppressed for 2 cycles.
  - Total mac_en pulses = 8.
- Assert rst at cycle 40.
  - All outputs are 0 the same cycle; busy=0.
  - A new start then completes a normal 100-cycle pass.
- Pulse start while busy, at cycle 50.
  - Ignored: no extra mem_rd and exactly one done.
